// File: rtl/auto_contrast_ctrl.sv
// auto_contrast_ctrl
// Closed-loop controller for the pixel contrast stage. It measures the luma
// spread (max - min) of every evaluated frame, emits one frame_en pulse per
// frame from the falling edge of vsync_n, and issues single-step inc/dec
// requests that steer the spread toward TARGET_SPREAD. A shadow copy of the
// contrast level (0..15) keeps it from requesting a step the stage cannot take.
module auto_contrast_ctrl #(
    parameter int TARGET_SPREAD = 160,
    parameter int HYST          = 16,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       vsync_n,
    input  logic       de,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    output logic       frame_en,
    output logic       inc,
    output logic       dec,
    output logic [3:0] level_shadow,
    output logic [7:0] spread
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Thresholds are kept signed and one bit wider than the spread so a
    // target band that falls outside 0..255 simply never triggers.
    localparam logic signed [9:0] LO_THR      = 10'(TARGET_SPREAD - HYST);
    localparam logic signed [9:0] HI_THR      = 10'(TARGET_SPREAD + HYST);
    localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE_FRAMES);
    localparam logic [3:0]        LEVEL_RST   = 4'd8;
    localparam logic [3:0]        LEVEL_MAX   = 4'd15;
    localparam logic [3:0]        LEVEL_MIN   = 4'd0;
    localparam logic [7:0]        MIN_INIT    = 8'hFF;
    localparam logic [7:0]        MAX_INIT    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,    // disabled: no requests, statistics held cleared
        ST_SETTLE,  // discarding frames while the picture settles
        ST_ACCUM,   // collecting min/max luma of the current frame
        ST_EVAL,    // frame_en cycle that closes a measured frame
        ST_HOLD     // inc/dec held until the contrast stage consumes it
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_q,    state_d;
    logic [3:0] settle_q,   settle_d;
    logic       inc_q,      inc_d;
    logic       dec_q,      dec_d;
    logic [3:0] level_q,    level_d;
    logic [7:0] spread_q,   spread_d;
    logic [7:0] min_q,      min_d;
    logic [7:0] max_q,      max_d;
    logic       seen_q,     seen_d;
    logic       vs_q;
    logic       frame_en_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              fe;
    logic [9:0]        luma_sum;
    logic [7:0]        luma;
    logic [7:0]        spread_w;
    logic signed [9:0] spread_s;
    logic              too_flat;
    logic              too_wide;
    logic              can_inc;
    logic              can_dec;

    // Frame edge: vsync_n was high last cycle and is low now.
    assign fe = vs_q & ~vsync_n;

    // Y = (R + 2G + B) >> 2 with a 10-bit sum; the low two bits are dropped.
    assign luma_sum = {2'b00, R} + {1'b0, G, 1'b0} + {2'b00, B};
    assign luma     = 8'(luma_sum >> 2);

    // A frame with no active pixels reports zero spread.
    assign spread_w = seen_q ? (max_q - min_q) : 8'd0;
    assign spread_s = $signed({2'b00, spread_w});

    assign too_flat = (spread_s < LO_THR);
    assign too_wide = (spread_s > HI_THR);
    assign can_inc  = (level_q != LEVEL_MAX);
    assign can_dec  = (level_q != LEVEL_MIN);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // State register; vsync sampling and frame_en run in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            settle_q   <= 4'd0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            level_q    <= LEVEL_RST;
            spread_q   <= 8'd0;
            min_q      <= MIN_INIT;
            max_q      <= MAX_INIT;
            seen_q     <= 1'b0;
            vs_q       <= 1'b1;
            frame_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            level_q    <= level_d;
            spread_q   <= spread_d;
            min_q      <= min_d;
            max_q      <= max_d;
            seen_q     <= seen_d;
            vs_q       <= vsync_n;
            frame_en_q <= fe;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Controller FSM: measurement, decision, request hold and settling.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        inc_d    = inc_q;
        dec_d    = dec_q;
        level_d  = level_q;
        spread_d = spread_q;
        min_d    = min_q;
        max_d    = max_q;
        seen_d   = seen_q;

        if (!enable) begin
            // Dropping enable abandons any pending request but leaves the
            // shadow level alone: the stage has not applied the step yet.
            state_d = ST_IDLE;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
            min_d   = MIN_INIT;
            max_d   = MAX_INIT;
            seen_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // The frame in progress is partial, so skip to its end.
                    inc_d    = 1'b0;
                    dec_d    = 1'b0;
                    min_d    = MIN_INIT;
                    max_d    = MAX_INIT;
                    seen_d   = 1'b0;
                    settle_d = 4'd0;
                    state_d  = ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (fe) begin
                        if (settle_q == 4'd0) begin
                            min_d   = MIN_INIT;
                            max_d   = MAX_INIT;
                            seen_d  = 1'b0;
                            state_d = ST_ACCUM;
                        end else begin
                            settle_d = settle_q - 4'd1;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (de) begin
                        if (luma < min_q) begin
                            min_d = luma;
                        end
                        if (luma > max_q) begin
                            max_d = luma;
                        end
                        seen_d = 1'b1;
                    end
                    if (fe) begin
                        state_d = ST_EVAL;
                    end
                end

                ST_EVAL: begin
                    spread_d = spread_w;
                    min_d    = MIN_INIT;
                    max_d    = MAX_INIT;
                    seen_d   = 1'b0;
                    if (!seen_q) begin
                        state_d = ST_ACCUM;
                    end else if (too_flat && can_inc) begin
                        inc_d   = 1'b1;
                        state_d = ST_HOLD;
                    end else if (too_wide && can_dec) begin
                        dec_d   = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end

                ST_HOLD: begin
                    // The contrast stage acts on the request in the frame_en
                    // cycle, so the shadow level follows in the same cycle.
                    if (frame_en_q) begin
                        if (inc_q) begin
                            level_d = level_q + 4'd1;
                        end else if (dec_q) begin
                            level_d = level_q - 4'd1;
                        end
                        inc_d    = 1'b0;
                        dec_d    = 1'b0;
                        settle_d = SETTLE_INIT;
                        state_d  = ST_SETTLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign frame_en     = frame_en_q;
    assign inc          = inc_q;
    assign dec          = dec_q;
    assign level_shadow = level_q;
    assign spread       = spread_q;

endmodule

// File: tb/tb_auto_contrast_ctrl.sv
// Testbench for auto_contrast_ctrl: directed frames with a frame-level model
// of the controller that schedules the expected output changes, compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_auto_contrast_ctrl;

    localparam int TARGET = 160;
    localparam int HYST   = 16;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       vsync_n = 1'b1;
    logic       de = 1'b0;
    logic [7:0] R = 8'd0;
    logic [7:0] G = 8'd0;
    logic [7:0] B = 8'd0;
    logic       frame_en;
    logic       inc;
    logic       dec;
    logic [3:0] level_shadow;
    logic [7:0] spread;

    auto_contrast_ctrl #(
        .TARGET_SPREAD(TARGET),
        .HYST         (HYST),
        .SETTLE_FRAMES(SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .vsync_n     (vsync_n),
        .de          (de),
        .R           (R),
        .G           (G),
        .B           (B),
        .frame_en    (frame_en),
        .inc         (inc),
        .dec         (dec),
        .level_shadow(level_shadow),
        .spread      (spread)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // ---------------- expected-output schedule ----------------
    localparam int F_FEN = 0, F_INC = 1, F_DEC = 2, F_LVL = 3, F_SPR = 4;
    typedef struct {
        int at;
        int field;
        int val;
    } ev_t;
    ev_t evq[$];
    ev_t keep_q[$];
    int  exp_fen = 0, exp_inc = 0, exp_dec = 0, exp_lvl = 8, exp_spr = 0;
    bit  chk_on = 1'b0;

    task automatic sched(input int at, input int f, input int v);
        ev_t e;
        e.at = at; e.field = f; e.val = v;
        evq.push_back(e);
    endtask

    task automatic apply_ev(input int f, input int v);
        case (f)
            F_FEN:   exp_fen = v;
            F_INC:   exp_inc = v;
            F_DEC:   exp_dec = v;
            F_LVL:   exp_lvl = v;
            default: exp_spr = v;
        endcase
    endtask

    // ---------------- frame-level controller model ----------------
    typedef enum int {M_OFF, M_SKIP, M_MEASURE, M_REQ} mode_t;
    mode_t m_mode = M_OFF;
    int    skip_left = 0;
    int    m_lvl = 8;
    int    req_dir = 0;
    int    st_lo = 255, st_hi = 0;
    bit    st_seen = 1'b0;

    task automatic stats_clear();
        st_lo = 255; st_hi = 0; st_seen = 1'b0;
    endtask

    task automatic fold(input int r, input int g, input int b);
        int y;
        y = (r + 2 * g + b) / 4;
        if (y < st_lo) st_lo = y;
        if (y > st_hi) st_hi = y;
        st_seen = 1'b1;
    endtask

    // Called when vsync_n has just been driven low at cycle k.
    task automatic model_fe(input int k);
        int sp;
        if (rst) return;
        sched(k + 1, F_FEN, 1);
        sched(k + 2, F_FEN, 0);
        if (!enable) return;
        case (m_mode)
            M_SKIP: begin
                if (skip_left == 0) begin
                    m_mode = M_MEASURE;
                    stats_clear();
                end else begin
                    skip_left--;
                end
            end
            M_MEASURE: begin
                sp = st_seen ? (st_hi - st_lo) : 0;
                sched(k + 2, F_SPR, sp);
                if (st_seen && sp < TARGET - HYST && m_lvl < 15) begin
                    req_dir = 1; m_mode = M_REQ; sched(k + 2, F_INC, 1);
                end else if (st_seen && sp > TARGET + HYST && m_lvl > 0) begin
                    req_dir = -1; m_mode = M_REQ; sched(k + 2, F_DEC, 1);
                end
                stats_clear();
            end
            M_REQ: begin
                m_lvl += req_dir;
                sched(k + 2, F_LVL, m_lvl);
                sched(k + 2, F_INC, 0);
                sched(k + 2, F_DEC, 0);
                m_mode = M_SKIP;
                skip_left = SETTLE;
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison against the scheduled expectations.
    always @(negedge clk) begin
        if (chk_on) begin
            keep_q.delete();
            foreach (evq[i]) begin
                if (evq[i].at <= cyc) apply_ev(evq[i].field, evq[i].val);
                else keep_q.push_back(evq[i]);
            end
            evq = keep_q;
            chk("frame_en", frame_en, exp_fen);
            chk("inc", inc, exp_inc);
            chk("dec", dec, exp_dec);
            chk("level_shadow", level_shadow, exp_lvl);
            chk("spread", spread, exp_spr);
            chk("inc_dec_exclusive", inc & dec, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [23:0] pq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pat_clear();
        pq.delete();
    endtask

    task automatic pat_add(input int r, input int g, input int b, input int n);
        for (int i = 0; i < n; i++) pq.push_back({8'(r), 8'(g), 8'(b)});
    endtask

    task automatic pat_flat();
        pat_clear();
        pat_add(128, 128, 128, 3);
    endtask

    // Active pixels of the current frame, then the frame edge that ends it.
    task automatic do_frame();
        foreach (pq[i]) begin
            R = pq[i][23:16]; G = pq[i][15:8]; B = pq[i][7:0]; de = 1'b1;
            if (m_mode == M_MEASURE && enable && !rst) fold(R, G, B);
            tick();
        end
        de = 1'b0; R = 8'd0; G = 8'd0; B = 8'd0;
        tick();
        vsync_n = 1'b0;
        model_fe(cyc);
        tick(); tick(); tick();
        vsync_n = 1'b1;
        tick(); tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic set_enable(input bit v);
        enable = v;
        if (!v) begin
            m_mode = M_OFF;
            sched(cyc + 1, F_INC, 0);
            sched(cyc + 1, F_DEC, 0);
        end else begin
            m_mode = M_SKIP;
            skip_left = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        evq.delete();
        sched(cyc + 1, F_FEN, 0);
        sched(cyc + 1, F_INC, 0);
        sched(cyc + 1, F_DEC, 0);
        sched(cyc + 1, F_LVL, 8);
        sched(cyc + 1, F_SPR, 0);
        m_mode = M_OFF; m_lvl = 8; stats_clear();
        tick(); tick();
        chk("rst_inc", inc, 0);
        chk("rst_dec", dec, 0);
        chk("rst_level", level_shadow, 8);
        chk("rst_spread", spread, 0);
        chk("rst_frame_en", frame_en, 0);
        rst = 1'b0;
        if (enable) begin
            m_mode = M_SKIP; skip_left = 0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held with vsync toggling; release with vsync high.
        tick();
        chk_on = 1'b1;
        vsync_n = 1'b0; tick();
        vsync_n = 1'b1; tick();
        vsync_n = 1'b0; tick();
        vsync_n = 1'b1; tick();
        chk("reset_frame_en", frame_en, 0);
        chk("reset_inc", inc, 0);
        chk("reset_dec", dec, 0);
        chk("reset_level", level_shadow, 8);
        chk("reset_spread", spread, 0);
        rst = 1'b0;
        tick(); tick();

        // First frame edge after release: single-cycle pulse at fe+1.
        vsync_n = 1'b0;
        model_fe(cyc);
        tick(); chk("fen_pulse_hi", frame_en, 1);
        tick(); chk("fen_pulse_lo", frame_en, 0);
        tick();
        vsync_n = 1'b1;
        tick(); tick();

        // Flat frames (Y=128): one discarded frame, then inc requests.
        set_enable(1'b1);
        pat_flat();
        frames(2);
        chk("flat_inc", inc, 1);
        chk("flat_spread", spread, 0);
        chk("flat_level_before", level_shadow, 8);
        frames(1);
        chk("flat_level_9", level_shadow, 9);
        chk("flat_inc_clear", inc, 0);
        frames(5);
        chk("flat_level_10", level_shadow, 10);

        // Drive to the top of the range; inc must stop at 15.
        frames(25);
        frames(6);
        chk("top_level_15", level_shadow, 15);
        chk("top_no_inc", inc, 0);

        // Black/white frames: spread 255 -> dec down to 0.
        pat_clear();
        pat_add(0, 0, 0, 1);
        pat_add(255, 255, 255, 1);
        frames(1);
        chk("wide_dec", dec, 1);
        chk("wide_inc_off", inc, 0);
        chk("wide_spread", spread, 255);
        frames(1);
        chk("wide_level_14", level_shadow, 14);
        chk("wide_dec_clear", dec, 0);
        frames(70);
        frames(4);
        chk("bottom_level_0", level_shadow, 0);
        chk("bottom_no_dec", dec, 0);
        chk("bottom_spread", spread, 255);

        // Non-grey luma weighting: (255,0,0)->63, (10,20,30)->20.
        pat_clear();
        pat_add(255, 0, 0, 1);
        pat_add(10, 20, 30, 1);
        frames(1);
        chk("luma_spread_43", spread, 43);
        chk("luma_inc", inc, 1);
        frames(1);
        chk("luma_level_1", level_shadow, 1);

        // Settle, then a frame with no active pixels.
        pat_flat();
        frames(3);
        pat_clear();
        frames(1);
        chk("nodata_spread", spread, 0);
        chk("nodata_inc", inc, 0);
        chk("nodata_dec", dec, 0);

        // Dead band and its edges.
        pat_clear();
        pat_add(40, 40, 40, 1);
        pat_add(255, 0, 0, 1);
        pat_add(200, 200, 200, 1);
        frames(1);
        chk("band_160", spread, 160);
        chk("band_160_inc", inc, 0);
        chk("band_160_dec", dec, 0);
        pat_clear();
        pat_add(30, 30, 30, 1);
        pat_add(174, 174, 174, 1);
        frames(1);
        chk("band_144", spread, 144);
        chk("band_144_inc", inc, 0);
        pat_clear();
        pat_add(30, 30, 30, 1);
        pat_add(206, 206, 206, 1);
        frames(1);
        chk("band_176", spread, 176);
        chk("band_176_dec", dec, 0);
        // (3,1,2) -> 7>>2 = 1 (truncated), so spread is 177.
        pat_clear();
        pat_add(3, 1, 2, 1);
        pat_add(178, 178, 178, 1);
        frames(1);
        chk("band_177", spread, 177);
        chk("band_177_dec", dec, 1);
        pat_flat();
        frames(1);
        chk("band_level_0", level_shadow, 0);

        // Reset while an inc request is held.
        do_reset();
        pat_flat();
        frames(2);
        chk("hold_rst_inc_before", inc, 1);
        do_reset();
        chk("hold_rst_level", level_shadow, 8);

        // Enable dropped while an inc request is held.
        pat_flat();
        frames(2);
        chk("hold_en_inc_before", inc, 1);
        set_enable(1'b0);
        tick();
        chk("hold_en_inc_clear", inc, 0);
        chk("hold_en_level", level_shadow, 8);
        frames(2);
        chk("disabled_level", level_shadow, 8);
        chk("disabled_inc", inc, 0);

        // Re-enable at level 8: dead band frames, then one dec step to 7.
        set_enable(1'b1);
        pat_flat();
        frames(1);
        pat_clear();
        pat_add(40, 40, 40, 1);
        pat_add(200, 200, 200, 1);
        frames(1);
        chk("re_band_160", spread, 160);
        chk("re_band_160_inc", inc, 0);
        pat_clear();
        pat_add(30, 30, 30, 1);
        pat_add(174, 174, 174, 1);
        frames(1);
        chk("re_band_144", spread, 144);
        chk("re_band_144_inc", inc, 0);
        pat_clear();
        pat_add(0, 0, 0, 1);
        pat_add(255, 255, 255, 1);
        frames(1);
        chk("re_dec", dec, 1);
        frames(1);
        chk("re_level_7", level_shadow, 7);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
